// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and sizing helpers for the instruction prefetch queue
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_DEPTH = 4;
    localparam int COUNT_W       = count_width(DEFAULT_DEPTH);

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular FIFO with wrap-bit pointers, flush and combinational head
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W     = 25,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic                   head_valid,
    output logic [W-1:0]           head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         empty;
    logic         full;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so push-on-full is accepted then
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[PW-1:0]] <= push_data;
    end

    assign count      = wr_ptr - rd_ptr;
    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch unit: fetch FSM, one outstanding read, redirect flush/drain
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int             AW       = 9,
    parameter int             IW       = 16,
    parameter int             DEPTH    = 4,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [AW-1:0]          mem_addr,
    input  logic [IW-1:0]          mem_rdata,
    input  logic                   mem_rvalid,
    output logic                   ir_valid,
    output logic [IW-1:0]          ir_data,
    output logic [AW-1:0]          ir_pc,
    input  logic                   ir_ready,
    input  logic                   redirect,
    input  logic [AW-1:0]          redirect_pc,
    input  logic                   halt,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = count_width(DEPTH);

    fetch_state_e     state;
    fetch_state_e     state_nx;
    logic [AW-1:0]    fetch_pc;
    logic [AW-1:0]    req_pc;
    logic             push;
    logic             pop;
    logic             issue;
    logic             space;
    logic [CW-1:0]    occ_next;
    logic [AW+IW-1:0] head_data;

    assign pop      = ir_valid && ir_ready && !redirect;
    assign push     = (state == WAIT) && mem_rvalid && !redirect;
    // one slot stays reserved for the response of the request issued now
    assign occ_next = count + CW'(push) - CW'(pop);
    assign space    = occ_next < CW'(DEPTH);

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        if (redirect) begin
            if (state == WAIT) state_nx = mem_rvalid ? FETCH : DRAIN;
        end else begin
            case (state)
                FETCH: if (space && !halt) begin
                    issue    = 1'b1;
                    state_nx = WAIT;
                end
                WAIT: if (mem_rvalid) begin
                    if (space && !halt) issue = 1'b1;
                    else                state_nx = FETCH;
                end
                DRAIN: if (mem_rvalid) state_nx = FETCH;
                default: state_nx = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else begin
            state <= state_nx;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 1'b1;
            end
        end
    end

    // outputs are forced low while reset is held even though FETCH would issue
    assign mem_req  = issue && reset;
    assign mem_addr = mem_req ? fetch_pc : '0;

    fetch_fifo #(
        .W     (AW + IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (push),
        .push_data  ({mem_rdata, req_pc}),
        .pop        (pop),
        .clear      (redirect),
        .head_valid (ir_valid),
        .head_data  (head_data),
        .count      (count)
    );

    assign {ir_data, ir_pc} = head_data;

`ifndef SYNTHESIS
    rvalid_not_in_fetch: assert property (@(posedge clk) disable iff (!reset)
        !(state == FETCH && mem_rvalid));
`endif

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch unit that replaces the single-instruction PC/instruction-register path of the RISC machine. It keeps a program counter and issues one-outstanding read requests to instruction memory. Returned words are buffered with their PC in a DEPTH-entry FIFO that the control FSM drains. A branch redirect flushes the queue, discards any in-flight response and restarts fetch at the target.

## Interface
- AW, 9, instruction address width
- IW, 16, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 0, fetch address after reset
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- mem_req  out  1  one-cycle read request pulse
- mem_addr  out  AW  request address; valid while mem_req=1
- mem_rdata  in  IW  returned instruction word
- mem_rvalid  in  1  response strobe; arrives ≥1 cycle after mem_req
- ir_valid  out  1  FIFO head valid
- ir_data  out  IW  FIFO head instruction
- ir_pc  out  AW  address of ir_data
- ir_ready  in  1  consumer pops the head when ir_valid&ir_ready
- redirect  in  1  branch taken; flush and restart
- redirect_pc  in  AW  new fetch address
- halt  in  1  level; stop issuing new requests
- count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Reset value of every output is 0; fetch_pc=RESET_PC; FSM=FETCH; FIFO empty.
- FSM states:
  - FETCH: if space and !halt, drive mem_req=1 and mem_addr=fetch_pc; latch req_pc=fetch_pc; fetch_pc+=1 (mod 2^AW); go to WAIT.
  - WAIT: on mem_rvalid, push {mem_rdata, req_pc}. In the same cycle, if space and !halt, issue the next request and stay in WAIT; otherwise go to FETCH.
  - DRAIN: wait for the stale response. On mem_rvalid, discard it and go to FETCH. No request is issued in DRAIN.
- space means occupancy after this cycle's push and pop is < DEPTH, with one slot reserved for the request being issued.
- redirect has the highest priority:
  - FIFO is cleared and the pop is ignored.
  - fetch_pc=redirect_pc.
  - From WAIT without mem_rvalid in that cycle, go to DRAIN.
  - From WAIT with mem_rvalid in that cycle, drop the response and go to FETCH.
  - From FETCH or DRAIN, stay put; DRAIN still owes one discard.
  - No mem_req in the redirect cycle.
- halt blocks new issue only. An in-flight response is still pushed, and queued entries stay poppable. Deassertion resumes at fetch_pc.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Pop when empty is ignored.
- mem_rvalid in FETCH is a protocol error: it is ignored, with a simulation-only assertion.

## Timing
- Reset deasserted before edge 0: mem_req=1, addr=RESET_PC in cycle 0.
- mem_rvalid in cycle k → ir_valid=1 in cycle k+1 (registered FIFO storage, combinational head).
- With 1-cycle memory and ir_ready=1, steady-state throughput is 1 instruction per cycle.
- After redirect in cycle r with no stale response pending, the first mem_req is in cycle r+1 and ir_valid no earlier than r+3.
- Asynchronous reset mid-operation clears FIFO, FSM and pending-drain state immediately. Any later mem_rvalid is treated as a protocol error.

## Structure
- Package fetch_pkg: state enum {FETCH, WAIT, DRAIN} and the localparam for the count width.
- Sub-module fetch_fifo (parametrised by width AW+IW and DEPTH) has push/pop/clear, circular pointers with a wrap bit, and a count output.
- fetch_queue holds the FSM, fetch_pc and req_pc.

## Test plan
- Reset, 1-cycle memory, ir_ready=1, memory returns 16'hA000+addr:
  - mem_addr = 0,1,2,… on consecutive cycles.
  - ir_pc/ir_data = 0/A000 in cycle 2, then one entry per cycle.
- ir_ready=0, DEPTH=4:
  - count reaches 4, mem_req stops, mem_addr stops at 4.
  - Raising ir_ready resumes with addr 4 and no duplicate or lost PC.
- 3-cycle memory latency, redirect to 9'h050 while WAIT: the stale response is discarded, the next mem_addr is 050, and the first ir_pc is 050.
- redirect in the same cycle as mem_rvalid and a pop: the FIFO is empty next cycle, no DRAIN is entered, and mem_req addr=redirect_pc the following cycle.
- halt=1 with a request in flight: the response is pushed, no further mem_req, and the queue drains to count=0. Releasing halt resumes at the next sequential PC.
- Wrap-around: RESET_PC=9'h1FE gives fetch addresses 1FE, 1FF, 000. Async reset mid-WAIT clears count to 0 and ir_valid to 0 before the next edge.
